// File: rtl/status_led_array.sv
// status_led_array: per-channel green/red LED pair with sticky fault blink.
// Ports: clk, rst_n, enable, dbstate/fault/fault_clr in; led_green/led_red/Y/fault_sticky out.
module status_led_array #(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 16,
  parameter int BLINK_DIV   = 25000,
  parameter int FAULT_LATCH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [N_CH-1:0] dbstate,
  input  logic [N_CH-1:0] fault,
  input  logic [N_CH-1:0] fault_clr,
  output logic [N_CH-1:0] led_green,
  output logic [N_CH-1:0] led_red,
  output logic [N_CH-1:0] Y,
  output logic [N_CH-1:0] fault_sticky
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RED,
    S_GREEN,
    S_FAULT
  } state_e;

  localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(BLINK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;
  logic [N_CH-1:0]  green_q, green_d;
  logic [N_CH-1:0]  red_q, red_d;
  logic [N_CH-1:0]  y_q, y_d;
  logic [N_CH-1:0]  sticky_q, sticky_d;
  state_e           state_q [N_CH];
  state_e           state_d [N_CH];

  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Sticky flag tracks fault every cycle, even while disabled.
  always_comb begin
    if (FAULT_LATCH != 0) begin
      sticky_d = fault | (sticky_q & ~fault_clr);
    end else begin
      sticky_d = fault;
    end
  end

  // FSM sees the registered sticky flag, so a clear shows one cycle later.
  always_comb begin
    green_d = green_q;
    red_d   = red_q;
    y_d     = y_q;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      if (enable) begin
        unique case (1'b1)
          sticky_q[i]:                 state_d[i] = S_FAULT;
          !sticky_q[i] && dbstate[i]:  state_d[i] = S_GREEN;
          default:                     state_d[i] = S_RED;
        endcase
        unique case (state_d[i])
          S_IDLE: begin
            green_d[i] = 1'b0;
            red_d[i]   = 1'b0;
            y_d[i]     = 1'b0;
          end
          S_RED: begin
            green_d[i] = 1'b0;
            red_d[i]   = 1'b1;
            y_d[i]     = 1'b0;
          end
          S_GREEN: begin
            green_d[i] = 1'b1;
            red_d[i]   = 1'b0;
            y_d[i]     = 1'b1;
          end
          S_FAULT: begin
            green_d[i] = 1'b0;
            red_d[i]   = blink_d;
            y_d[i]     = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      blink_q  <= 1'b0;
      green_q  <= '0;
      red_q    <= '0;
      y_q      <= '0;
      sticky_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= S_IDLE;
      end
    end else begin
      cnt_q    <= cnt_d;
      blink_q  <= blink_d;
      green_q  <= green_d;
      red_q    <= red_d;
      y_q      <= y_d;
      sticky_q <= sticky_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign led_green    = green_q;
  assign led_red      = red_q;
  assign Y            = y_q;
  assign fault_sticky = sticky_q;

endmodule

// File: tb/tb_status_led_array.sv
// tb_status_led_array: directed vector table plus reset/random sequences.
// Drives on negedge, samples on the following negedge.
module tb_status_led_array;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] dbstate;
  logic [3:0] fault;
  logic [3:0] fault_clr;
  logic [3:0] led_green;
  logic [3:0] led_red;
  logic [3:0] Y;
  logic [3:0] fault_sticky;

  int checks;
  int failures;

  status_led_array #(
    .N_CH(4),
    .DIV_W(16),
    .BLINK_DIV(4),
    .FAULT_LATCH(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .dbstate(dbstate),
    .fault(fault),
    .fault_clr(fault_clr),
    .led_green(led_green),
    .led_red(led_red),
    .Y(Y),
    .fault_sticky(fault_sticky)
  );

  typedef struct {
    logic       en;
    logic [3:0] db;
    logic [3:0] f;
    logic [3:0] clr;
    logic [3:0] g;
    logic [3:0] r;
    logic [3:0] y;
    logic [3:0] st;
  } vec_t;

  vec_t vt [17];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] g,
                         input logic [3:0] r, input logic [3:0] y,
                         input logic [3:0] st);
    chk({nm, " green"}, led_green, g);
    chk({nm, " red"}, led_red, r);
    chk({nm, " y"}, Y, y);
    chk({nm, " sticky"}, fault_sticky, st);
  endtask

  task automatic drive(input logic en, input logic [3:0] db,
                       input logic [3:0] f, input logic [3:0] clr);
    enable    = en;
    dbstate   = db;
    fault     = f;
    fault_clr = clr;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    //           en    db       f        clr      g        r        y        st
    vt[0]  = '{1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0101, 4'b1010, 4'b0101, 4'b0000};
    vt[1]  = '{1'b1, 4'b0101, 4'b0100, 4'b0000, 4'b0101, 4'b1010, 4'b0101, 4'b0100};
    vt[2]  = '{1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b1010, 4'b0001, 4'b0100};
    vt[3]  = '{1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b1110, 4'b0001, 4'b0100};
    vt[4]  = '{1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b1110, 4'b0001, 4'b0100};
    vt[5]  = '{1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b1110, 4'b0001, 4'b0100};
    vt[6]  = '{1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b1110, 4'b0001, 4'b0100};
    vt[7]  = '{1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b1010, 4'b0001, 4'b0100};
    vt[8]  = '{1'b1, 4'b0101, 4'b0000, 4'b0100, 4'b0001, 4'b1010, 4'b0001, 4'b0000};
    vt[9]  = '{1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0101, 4'b1010, 4'b0101, 4'b0000};
    vt[10] = '{1'b1, 4'b0101, 4'b0100, 4'b0100, 4'b0101, 4'b1010, 4'b0101, 4'b0100};
    vt[11] = '{1'b1, 4'b0101, 4'b0000, 4'b0100, 4'b0001, 4'b1110, 4'b0001, 4'b0000};
    vt[12] = '{1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0101, 4'b1010, 4'b0101, 4'b0000};
    vt[13] = '{1'b0, 4'b1010, 4'b0010, 4'b0000, 4'b0101, 4'b1010, 4'b0101, 4'b0010};
    vt[14] = '{1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0101, 4'b1010, 4'b0101, 4'b0010};
    vt[15] = '{1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0101, 4'b1010, 4'b0101, 4'b0010};
    vt[16] = '{1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0101, 4'b1010, 4'b0101, 4'b0010};

    rst_n = 1'b0;
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
    #12;
    chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].en, vt[i].db, vt[i].f, vt[i].clr);
      @(negedge clk);
      chk_all($sformatf("v%0d", i), vt[i].g, vt[i].r, vt[i].y, vt[i].st);
    end

    for (int c = 0; c < 2000; c++) begin
      drive(1'b1, dbstate ^ 4'b1111, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
      @(negedge clk);
      chk("excl", led_green & led_red, 4'b0000);
      chk("y_eq_green", Y, led_green);
    end

    drive(1'b1, 4'b0000, 4'b0000, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    drive(1'b1, 4'b0000, 4'b0001, 4'b0000);
    @(negedge clk);
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000);
    for (int c = 0; c < 5; c++) @(negedge clk);
    chk("pre_rst red", led_red & 4'b1110, 4'b1110);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("idle_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    drive(1'b1, 4'b0000, 4'b0001, 4'b0000);
    @(negedge clk);
    chk_all("post_e1", 4'b0000, 4'b1111, 4'b0000, 4'b0001);
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    chk_all("post_e2", 4'b0000, 4'b1110, 4'b0000, 4'b0001);
    @(negedge clk);
    chk_all("post_e3", 4'b0000, 4'b1110, 4'b0000, 4'b0001);
    @(negedge clk);
    chk_all("post_e4", 4'b0000, 4'b1111, 4'b0000, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
